// File: rtl/slice_add_arb_pkg.sv
// Shared types and constants for the slice-and-add arbiter.
package slice_add_arb_pkg;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

    localparam int unsigned PERF_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority picker: grants the first requester at or after ptr_i, modulo N.
module rr_arbiter #(
    parameter  int unsigned N   = 4,
    localparam int unsigned IdW = $clog2(N)
) (
    input  logic [IdW-1:0] ptr_i,
    input  logic [N-1:0]   req_i,
    output logic [N-1:0]   grant_o,
    output logic [IdW-1:0] grant_idx_o
);

    logic         found;
    logic [IdW:0] pos;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        pos         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // One extra bit so the wrap also works for non-power-of-2 N.
            pos = {1'b0, ptr_i} + (IdW+1)'(k);
            if (pos >= (IdW+1)'(N)) begin
                pos = pos - (IdW+1)'(N);
            end
            if (!found && req_i[pos[IdW-1:0]]) begin
                found                 = 1'b1;
                grant_o[pos[IdW-1:0]] = 1'b1;
                grant_idx_o           = pos[IdW-1:0];
            end
        end
    end

endmodule

// File: rtl/slice_add_arbiter.sv
// Round-robin shared slice-and-add datapath with one registered result slot.
// Optional accepted-op counter enabled by defining SLICE_ADD_ARB_PERF_EN.
module slice_add_arbiter
    import slice_add_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    parameter  int unsigned A_W   = 3,
    parameter  int unsigned B_W   = 2,
    localparam int unsigned SEL_W = (B_W > 1) ? $clog2(B_W) : 1,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*A_W-1:0]   req_a,
    input  logic [N_REQ*B_W-1:0]   req_b,
    input  logic [N_REQ*SEL_W-1:0] req_sel,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [A_W:0]           rsp_data,
    output logic [ID_W-1:0]        rsp_id
`ifdef SLICE_ADD_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0]      perf_count
`endif
);

    slot_state_t      state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [A_W:0]     data_q, data_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             can_accept;
    logic             accept;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic [A_W-1:0]   a_sel;
    logic [B_W-1:0]   b_sel;
    logic [SEL_W-1:0] sel_sel;
    logic             sliced;

    assign can_accept = (state_q == SLOT_EMPTY) | (rsp_valid & rsp_ready);

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .ptr_i       (ptr_q),
        .req_i       (req_valid & {N_REQ{can_accept}}),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    // Slot FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL:  if (rsp_ready && !accept) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // Slot FSM: outputs.
    always_comb begin
        rsp_valid = (state_q == SLOT_FULL);
    end

    always_comb begin
        a_sel   = req_a[grant_idx*A_W +: A_W];
        b_sel   = req_b[grant_idx*B_W +: B_W];
        sel_sel = req_sel[grant_idx*SEL_W +: SEL_W];
        sliced  = 1'b0;
        if (32'(sel_sel) < B_W) begin
            sliced = b_sel[sel_sel];
        end
        data_d = data_q;
        id_d   = id_q;
        ptr_d  = ptr_q;
        if (accept) begin
            data_d = {1'b0, a_sel} + (A_W+1)'(sliced);
            id_d   = grant_idx;
            ptr_d  = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            id_q   <= '0;
            ptr_q  <= '0;
        end else begin
            data_q <= data_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
        end
    end

    assign rsp_data = data_q;
    assign rsp_id   = id_q;

`ifdef SLICE_ADD_ARB_PERF_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (accept && (perf_q != '1)) begin
            perf_d = perf_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_count = perf_q;
`else
    // Default build carries no counter.
`endif

endmodule

// File: tb/tb_slice_add_arbiter.sv
// Self-checking bench: behavioural slot/round-robin model plus directed literal checks.
module tb_slice_add_arbiter;

    localparam int N     = 4;
    localparam int A_W   = 3;
    localparam int B_W   = 2;
    localparam int SEL_W = 1;
    localparam int ID_W  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*A_W-1:0]     req_a;
    logic [N*B_W-1:0]     req_b;
    logic [N*SEL_W-1:0]   req_sel;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [A_W:0]         rsp_data;
    logic [ID_W-1:0]      rsp_id;
`ifdef SLICE_ADD_ARB_PERF_EN
    logic [15:0]          perf_count;
`endif

    slice_add_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
`ifdef SLICE_ADD_ARB_PERF_EN
        ,
        .perf_count (perf_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    int m_ptr;
    bit m_full;
    int m_data;
    int m_id;
    int m_perf;
    logic [N-1:0] last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        bit can = !m_full || (rsp_ready === 1'b1);
        if (!can) return -1;
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic int op_result(input int i);
        int a   = int'(req_a[i*A_W +: A_W]);
        int b   = int'(req_b[i*B_W +: B_W]);
        int sel = int'(req_sel[i*SEL_W +: SEL_W]);
        int bt  = (sel < B_W) ? ((b >> sel) & 1) : 0;
        return a + bt;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_full = 0;
        m_data = 0;
        m_id   = 0;
        m_perf = 0;
    endtask

    // Called just after a rising edge with inputs already driven.
    task automatic step();
        int g;
        logic [N-1:0] er;
        @(negedge clk);
        g  = exp_grant();
        er = (g < 0) ? '0 : (N'(1) << g);
        last_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            chk("rsp_data", 32'(rsp_data), 32'(m_data));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
        end
`ifdef SLICE_ADD_ARB_PERF_EN
        chk("perf_count", 32'(perf_count), 32'(m_perf));
`endif
        if (g >= 0) begin
            m_data = op_result(g);
            m_id   = g;
            m_full = 1;
            m_ptr  = (g + 1) % N;
            if (m_perf < 16'hFFFF) m_perf++;
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_ops();
        req_a   = N*A_W'($urandom);
        req_b   = N*B_W'($urandom);
        req_sel = N*SEL_W'($urandom);
    endtask

    initial begin
        logic [ID_W-1:0]  held_id;
        logic [A_W:0]     held_data;
        logic [N-1:0]     seq [5];
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;
        last_ready = '0;
        do_reset();

        // Reset state, no requests
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_data", 32'(rsp_data), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);

        // Requester 2 alone: a=7, b=2'b10, sel=1 -> 8
        req_valid        = 4'b0100;
        req_a[2*A_W +: A_W]       = 3'd7;
        req_b[2*B_W +: B_W]       = 2'b10;
        req_sel[2*SEL_W +: SEL_W] = 1'b1;
        step();
        chk("single req_ready", 32'(last_ready), 32'b0100);
        req_valid = '0;
        chk("single rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single rsp_data", 32'(rsp_data), 32'd8);
        chk("single rsp_id", 32'(rsp_id), 32'd2);
        rsp_ready = 1'b1;
        step();

        // All valid, rsp_ready=1: grants 0,1,2,3,0
        do_reset();
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            step();
            seq[i] = last_ready;
        end
        chk("rr grant0", 32'(seq[0]), 32'b0001);
        chk("rr grant1", 32'(seq[1]), 32'b0010);
        chk("rr grant2", 32'(seq[2]), 32'b0100);
        chk("rr grant3", 32'(seq[3]), 32'b1000);
        chk("rr grant4", 32'(seq[4]), 32'b0001);

        // Backpressure hold for 3 cycles
        rsp_ready = 1'b0;
        held_id   = rsp_id;
        held_data = rsp_data;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step();
            chk("hold req_ready", 32'(last_ready), 32'd0);
            chk("hold rsp_id", 32'(rsp_id), 32'(held_id));
            chk("hold rsp_data", 32'(rsp_data), 32'(held_data));
        end
        rsp_ready = 1'b1;
        step();
        chk("release grant", 32'(last_ready), 32'b0010);

        // Asynchronous reset mid-cycle while FULL
        chk("pre-reset full", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset rsp_valid", 32'(rsp_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = '1;
        step();
        chk("post-reset grant", 32'(last_ready), 32'b0001);

`ifdef SLICE_ADD_ARB_PERF_EN
        do_reset();
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("perf five", 32'(perf_count), 32'd5);
        for (int i = 0; i < 65535; i++) step();
        chk("perf saturate", 32'(perf_count), 32'hFFFF);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
